// File: rtl/cms1_rand_pkg.sv
// rtl/cms1_rand_pkg.sv - shared types and LFSR constants for the CMS1 randomness source
package cms1_rand_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_WARMUP,
        ST_RUN,
        ST_EXHAUSTED
    } rand_state_e;

    localparam int LFSR_W = 128;
    localparam int TAP_A  = 127;
    localparam int TAP_B  = 125;
    localparam int TAP_C  = 100;
    localparam int TAP_D  = 98;

    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 128'h1;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/cms1_lfsr_adv.sv
// rtl/cms1_lfsr_adv.sv - combinational RW-step advance of the 128-bit LFSR
module cms1_lfsr_adv
    import cms1_rand_pkg::*;
#(
    parameter int RW = 76
) (
    input  logic [LFSR_W-1:0] s_in,
    output logic [LFSR_W-1:0] s_out
);

    always_comb begin
        logic [LFSR_W-1:0] v;
        v = s_in;
        for (int i = 0; i < RW; i++) begin
            v = lfsr_step(v);
        end
        s_out = v;
    end

endmodule

// File: rtl/cms1_rand_source.sv
// rtl/cms1_rand_source.sv - seeded LFSR randomness stream with warm-up and reseed limit
module cms1_rand_source
    import cms1_rand_pkg::*;
#(
    parameter int RW        = 76,
    parameter int WARMUP    = 16,
    parameter int MAX_WORDS = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      seed,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic [RW-1:0]     r_out,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              reseed_req
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int WNW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [WNW-1:0] WORD_LAST = WNW'(MAX_WORDS - 1);

    rand_state_e       state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [WCW-1:0]    warm_cnt_q, warm_cnt_d;
    logic [WNW-1:0]    word_cnt_q, word_cnt_d;

    cms1_lfsr_adv #(.RW(RW)) u_adv (
        .s_in  (lfsr_q),
        .s_out (lfsr_adv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNSEEDED;
            lfsr_q     <= '0;
            warm_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // A seed load overrides everything, including a word being taken this cycle.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        warm_cnt_d = warm_cnt_q;
        word_cnt_d = word_cnt_q;
        if (seed_valid) begin
            lfsr_d     = (seed == '0) ? ZERO_SEED_SUB : seed;
            warm_cnt_d = '0;
            word_cnt_d = '0;
            state_d    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    lfsr_d     = lfsr_adv;
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (r_ready) begin
                        lfsr_d     = lfsr_adv;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == WORD_LAST) state_d = ST_EXHAUSTED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seed_ready = 1'b1;
        r_valid    = (state_q == ST_RUN);
        reseed_req = (state_q == ST_EXHAUSTED);
        r_out      = lfsr_q[RW-1:0];
    end

endmodule

// File: tb/tb_cms1_rand_source.sv
// tb/tb_cms1_rand_source.sv - self-checking bench for cms1_rand_source
module tb_cms1_rand_source;

    localparam int RW = 76;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0]  a_seed = '0, b_seed = '0;
    logic          a_seed_valid = 1'b0, b_seed_valid = 1'b0;
    logic          a_r_ready = 1'b0, b_r_ready = 1'b0;
    logic          a_seed_ready, b_seed_ready;
    logic [RW-1:0] a_r_out, b_r_out;
    logic          a_r_valid, b_r_valid;
    logic          a_reseed_req, b_reseed_req;

    cms1_rand_source #(.RW(RW), .WARMUP(0), .MAX_WORDS(2000)) u_a (
        .clk(clk), .rst(rst), .seed(a_seed), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .r_out(a_r_out), .r_valid(a_r_valid),
        .r_ready(a_r_ready), .reseed_req(a_reseed_req)
    );

    cms1_rand_source #(.RW(RW), .WARMUP(16), .MAX_WORDS(4)) u_b (
        .clk(clk), .rst(rst), .seed(b_seed), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .r_out(b_r_out), .r_valid(b_r_valid),
        .r_ready(b_r_ready), .reseed_req(b_reseed_req)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];
    logic [127:0]  ma, mb;

    typedef struct {
        logic [127:0]  seed;
        int            nfires;
        logic [RW-1:0] first_word;
    } vec_t;

    function automatic logic [127:0] m_step(input logic [127:0] s);
        logic fb;
        fb = s[127] ^ s[125] ^ s[100] ^ s[98];
        return {s[126:0], fb};
    endfunction

    function automatic logic [127:0] m_adv(input logic [127:0] s);
        logic [127:0] v;
        v = s;
        for (int i = 0; i < RW; i++) v = m_step(v);
        return v;
    endfunction

    function automatic logic [127:0] m_adv16(input logic [127:0] s);
        logic [127:0] v;
        v = s;
        for (int i = 0; i < 16; i++) v = m_adv(v);
        return v;
    endfunction

    function automatic logic [127:0] m_seed(input logic [127:0] s);
        return (s == '0) ? 128'h1 : s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pop_chk(input string nm);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h expected a queued word", nm, a_r_out);
        end else begin
            chk(nm, {52'h0, a_r_out}, {52'h0, exp_q.pop_front()});
        end
    endtask

    task automatic a_load(input logic [127:0] s);
        a_seed       = s;
        a_seed_valid = 1'b1;
        tick();
        a_seed_valid = 1'b0;
        ma = m_seed(s);
        exp_q.push_back(ma[RW-1:0]);
    endtask

    task automatic a_fire();
        a_r_ready = 1'b1;
        ma = m_adv(ma);
        exp_q.push_back(ma[RW-1:0]);
        tick();
        a_r_ready = 1'b0;
    endtask

    vec_t vecs[3];

    initial begin
        logic [127:0] s;
        logic [RW-1:0] held;
        int delivered;

        vecs[0] = '{seed: 128'h0, nfires: 3, first_word: 76'h1};
        vecs[1] = '{seed: 128'h1, nfires: 1000, first_word: 76'h1};
        vecs[2] = '{seed: 128'h0123456789ABCDEF_FEDCBA9876543210, nfires: 40,
                    first_word: 76'hDEF_FEDCBA9876543210};

        repeat (3) tick();
        chk("rst_a_r_valid", {127'h0, a_r_valid}, 128'h0);
        chk("rst_a_reseed_req", {127'h0, a_reseed_req}, 128'h0);
        chk("rst_a_seed_ready", {127'h0, a_seed_ready}, 128'h1);
        chk("rst_a_r_out", {52'h0, a_r_out}, 128'h0);
        chk("rst_b_r_valid", {127'h0, b_r_valid}, 128'h0);
        chk("rst_b_r_out", {52'h0, b_r_out}, 128'h0);
        rst = 1'b0;
        tick();
        chk("unseeded_a_r_valid", {127'h0, a_r_valid}, 128'h0);

        for (int v = 0; v < 3; v++) begin
            a_load(vecs[v].seed);
            chk("load_r_valid", {127'h0, a_r_valid}, 128'h1);
            chk("load_first_word", {52'h0, a_r_out}, {52'h0, vecs[v].first_word});
            a_pop_chk("stream_word0");
            for (int k = 0; k < vecs[v].nfires; k++) begin
                a_fire();
                a_pop_chk("stream_word");
            end
        end

        a_load(128'h1);
        a_pop_chk("adv1_load");
        a_fire();
        chk("adv1_r_out", {52'h0, a_r_out}, 128'h0);
        chk("adv1_state", u_a.lfsr_q, 128'h1 << 76);
        a_pop_chk("adv1_word");

        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        a_load(s);
        a_pop_chk("bp_load");
        for (int k = 0; k < 3; k++) begin
            a_fire();
            a_pop_chk("bp_pre");
        end
        held = ma[RW-1:0];
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("bp_hold_r_out", {52'h0, a_r_out}, {52'h0, held});
        end
        chk("bp_hold_valid", {127'h0, a_r_valid}, 128'h1);
        chk("bp_word_cnt", 128'(u_a.word_cnt_q), 128'd3);
        for (int k = 0; k < 5; k++) begin
            a_fire();
            a_pop_chk("bp_resume");
        end

        s = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        a_seed       = s;
        a_seed_valid = 1'b1;
        a_r_ready    = 1'b1;
        tick();
        a_seed_valid = 1'b0;
        a_r_ready    = 1'b0;
        ma = m_seed(s);
        chk("coll_a_r_out", {52'h0, a_r_out}, {52'h0, s[RW-1:0]});
        chk("coll_a_r_valid", {127'h0, a_r_valid}, 128'h1);
        chk("coll_a_word_cnt", 128'(u_a.word_cnt_q), 128'd0);

        s = 128'h0F0F_1234_5678_9ABC_DEF0_1357_9BDF_2468;
        b_seed       = s;
        b_seed_valid = 1'b1;
        tick();
        b_seed_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("warm_r_valid_low", {127'h0, b_r_valid}, 128'h0);
            tick();
        end
        mb = m_adv16(m_seed(s));
        chk("warm_r_valid_high", {127'h0, b_r_valid}, 128'h1);
        chk("warm_first_word", {52'h0, b_r_out}, {52'h0, mb[RW-1:0]});

        delivered = 0;
        b_r_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (b_r_valid) begin
                delivered++;
                chk("exh_word", {52'h0, b_r_out}, {52'h0, mb[RW-1:0]});
                mb = m_adv(mb);
            end
            tick();
        end
        chk("exh_delivered", 128'(delivered), 128'd4);
        for (int k = 0; k < 20; k++) begin
            chk("exh_r_valid", {127'h0, b_r_valid}, 128'h0);
            chk("exh_reseed_req", {127'h0, b_reseed_req}, 128'h1);
            chk("exh_r_out_hold", {52'h0, b_r_out}, {52'h0, mb[RW-1:0]});
            tick();
        end
        chk("exh_seed_ready", {127'h0, b_seed_ready}, 128'h1);
        b_r_ready = 1'b0;

        s = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
        b_seed       = s;
        b_seed_valid = 1'b1;
        tick();
        b_seed_valid = 1'b0;
        chk("reseed_req_drop", {127'h0, b_reseed_req}, 128'h0);
        chk("reseed_r_valid", {127'h0, b_r_valid}, 128'h0);
        repeat (16) tick();
        mb = m_adv16(m_seed(s));
        chk("reseed_r_valid_high", {127'h0, b_r_valid}, 128'h1);
        chk("reseed_first_word", {52'h0, b_r_out}, {52'h0, mb[RW-1:0]});

        s = 128'h1357_2468_ACE0_BDF1_0000_0000_0000_0042;
        b_seed       = s;
        b_seed_valid = 1'b1;
        b_r_ready    = 1'b1;
        tick();
        b_seed_valid = 1'b0;
        b_r_ready    = 1'b0;
        chk("coll_b_r_valid", {127'h0, b_r_valid}, 128'h0);
        repeat (16) tick();
        mb = m_adv16(m_seed(s));
        chk("coll_b_first_word", {52'h0, b_r_out}, {52'h0, mb[RW-1:0]});
        chk("coll_b_r_valid_high", {127'h0, b_r_valid}, 128'h1);

        a_fire();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_a_r_valid", {127'h0, a_r_valid}, 128'h0);
        chk("arst_a_r_out", {52'h0, a_r_out}, 128'h0);
        chk("arst_b_r_valid", {127'h0, b_r_valid}, 128'h0);
        chk("arst_b_r_out", {52'h0, b_r_out}, 128'h0);
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_a_r_valid", {127'h0, a_r_valid}, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
